mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DW, 32, datapath width in bits.
REQ-002 Parameter RW, 5, register-number width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hold MEM/WB register contents this cycle.
REQ-006 flush  input  1  insert bubble into MEM/WB register this cycle.
REQ-007 m_valid  input  1  MEM stage holds a real instruction.
REQ-008 m_wreg  input  1  MEM instruction writes register file.
REQ-009 m_m2reg  input  1  write-back data comes from memory (load), else ALU.
REQ-010 m_rn  input  RW  destination register number.
REQ-011 m_alu  input  DW  ALU result / effective address from MEM stage.
REQ-012 m_mo  input  DW  data-memory read data (combinational dataout of memory stage).
REQ-013 id_rs, id_rt  input  RW each  source register numbers of instruction in decode.
REQ-014 w_valid  output  1  WB stage holds a real instruction.
REQ-015 w_wreg  output  1  register-file write enable.
REQ-016 w_rn  output  RW  register-file write address.
REQ-017 w_wdi  output  DW  register-file write data.
REQ-018 fwd_a, fwd_b  output  1 each  WB result must be forwarded to decode rs / rt.
REQ-019 retired  output  32  count of instructions retired from WB.

Function
REQ-020 Registered fields: valid, wreg, m2reg, rn, alu, mo; all load on rising clk when neither stall nor flush asserted.
REQ-021 Latency: MEM-stage values appear on WB outputs exactly one clock after the capturing edge.
REQ-022 stall=1: all registered fields hold previous values; retired does not increment.
REQ-023 flush=1 (regardless of stall): valid<=0, wreg<=0, m2reg<=0, rn<=0, alu<=0, mo<=0; flush wins over stall.
REQ-024 m_valid=0 captured: wreg field stored as 0 regardless of m_wreg.
REQ-025 w_wdi = registered mo when registered m2reg=1, else registered alu; combinational from registers only.
REQ-026 w_wreg = registered valid AND registered wreg AND (registered rn != 0); register 0 never written.
REQ-027 w_rn = registered rn; w_valid = registered valid.
REQ-028 fwd_a = w_wreg AND (w_rn == id_rs); fwd_b = w_wreg AND (w_rn == id_rt); combinational.
REQ-029 retired increments by 1 on each rising clk where registered valid=1 and stall=0; wraps 0xFFFFFFFF -> 0x00000000.
REQ-030 Simultaneous flush and retiring instruction: instruction currently in WB still counts; incoming slot becomes bubble.
REQ-031 No internal combinational path from m_* inputs to any output.

Reset
REQ-032 clrn=0 asynchronously forces valid, wreg, m2reg, rn, alu, mo, retired to 0, independent of clk.
REQ-033 During and after reset until first capture: w_valid=0, w_wreg=0, w_rn=0, w_wdi=0, fwd_a=0, fwd_b=0, retired=0.
REQ-034 Reset asserted mid-stall or mid-flush: reset values take priority; first capture occurs on first rising clk with clrn=1.

Verification
REQ-035 Load: m_valid=1,m_wreg=1,m_m2reg=1,m_rn=3,m_alu=0x4,m_mo=0x0000000A, one edge -> w_wreg=1,w_rn=3,w_wdi=0x0000000A, next edge retired=1.
REQ-036 ALU op: m_m2reg=0,m_alu=0x12345678,m_rn=7,m_wreg=1 -> w_wdi=0x12345678; id_rs=7,id_rt=2 -> fwd_a=1,fwd_b=0.
REQ-037 R0 write: m_wreg=1,m_rn=0,m_alu=0xFFFFFFFF -> w_wreg=0, fwd_a=0 with id_rs=0; retired still increments.
REQ-038 Stall then flush: capture rn=5, assert stall 3 cycles -> outputs hold, retired unchanged; assert stall+flush -> w_valid=0,w_wreg=0,w_wdi=0.
REQ-039 Async reset: drive clrn=0 between clock edges with w_wreg=1 -> all outputs 0 immediately, before next edge.
REQ-040 Wrap: force 0xFFFFFFFF retirements (or preload via long run at reduced width) -> next retire gives retired=0x00000000.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage inputs, decode source registers, and WB outputs.
//   master : drives stall/flush, m_* and id_*; observes w_*, fwd_*, retired
//   slave  : the mem_wb_stage side (mirror of master)
// DW = datapath width, RW = register-number width, CW = retired-counter width.
interface mem_wb_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 32
);
  logic          stall;
  logic          flush;
  logic          m_valid;
  logic          m_wreg;
  logic          m_m2reg;
  logic [RW-1:0] m_rn;
  logic [DW-1:0] m_alu;
  logic [DW-1:0] m_mo;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          w_valid;
  logic          w_wreg;
  logic [RW-1:0] w_rn;
  logic [DW-1:0] w_wdi;
  logic          fwd_a;
  logic          fwd_b;
  logic [CW-1:0] retired;

  modport master (
    output stall, flush, m_valid, m_wreg, m_m2reg, m_rn, m_alu, m_mo, id_rs, id_rt,
    input  w_valid, w_wreg, w_rn, w_wdi, fwd_a, fwd_b, retired
  );

  modport slave (
    input  stall, flush, m_valid, m_wreg, m_m2reg, m_rn, m_alu, m_mo, id_rs, id_rt,
    output w_valid, w_wreg, w_rn, w_wdi, fwd_a, fwd_b, retired
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, WB->decode forwarding
// detection and a retired-instruction counter.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : mem_wb_stage_if slave (stall/flush, m_* in, id_rs/id_rt in,
//          w_valid/w_wreg/w_rn/w_wdi, fwd_a/fwd_b, retired out)
// Every output derives from stage registers plus id_rs/id_rt only; there is
// no combinational path from m_* to any output.
module mem_wb_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 32
) (
  input  logic         clk,
  input  logic         clrn,
  mem_wb_stage_if.slave bus
);

  logic          valid_q;
  logic          wreg_q;
  logic          m2reg_q;
  logic [RW-1:0] rn_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] mo_q;
  logic [CW-1:0] retired_q;
  logic          wreg_c;

  // Stage register: flush inserts a bubble and overrides stall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      rn_q    <= '0;
      alu_q   <= '0;
      mo_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      rn_q    <= '0;
      alu_q   <= '0;
      mo_q    <= '0;
    end else if (!bus.stall) begin
      valid_q <= bus.m_valid;
      wreg_q  <= bus.m_valid & bus.m_wreg;  // bubbles never carry a write enable
      m2reg_q <= bus.m_m2reg;
      rn_q    <= bus.m_rn;
      alu_q   <= bus.m_alu;
      mo_q    <= bus.m_mo;
    end
  end

  // Retire counter: the instruction leaving WB counts even when a flush
  // replaces the incoming slot; a stall keeps it in WB so it does not count.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      retired_q <= '0;
    end else if (valid_q && !bus.stall) begin
      retired_q <= retired_q + CW'(1);
    end
  end

  // Register 0 is hard-wired, so writes to it are suppressed.
  assign wreg_c = valid_q & wreg_q & (rn_q != '0);

  assign bus.w_valid = valid_q;
  assign bus.w_wreg  = wreg_c;
  assign bus.w_rn    = rn_q;
  assign bus.w_wdi   = m2reg_q ? mo_q : alu_q;
  assign bus.fwd_a   = wreg_c & (rn_q == bus.id_rs);
  assign bus.fwd_b   = wreg_c & (rn_q == bus.id_rt);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage. The driver applies one directed vector
// per clock and queues the hand-computed WB outputs expected after that edge;
// the monitor pops and compares shortly after each rising edge. A second
// instance with a 4-bit retire counter shares the stimulus to exercise wrap.
module tb_mem_wb_stage;

  typedef struct {
    logic        stall, flush, mv, mw, mm;
    logic [4:0]  rn;
    logic [31:0] alu, mo;
    logic [4:0]  rs, rt;
    logic        ev, ew;
    logic [4:0]  ern;
    logic [31:0] ewdi;
    logic        efa, efb;
    logic [31:0] eret;
  } vec_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t expq[$];

  mem_wb_stage_if #(.DW(32), .RW(5), .CW(32)) bus ();
  mem_wb_stage_if #(.DW(32), .RW(5), .CW(4))  sbus ();

  mem_wb_stage #(.DW(32), .RW(5), .CW(32)) u_dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  mem_wb_stage #(.DW(32), .RW(5), .CW(4)) u_small (
    .clk  (clk),
    .clrn (clrn),
    .bus  (sbus.slave)
  );

  assign sbus.stall   = bus.stall;
  assign sbus.flush   = bus.flush;
  assign sbus.m_valid = bus.m_valid;
  assign sbus.m_wreg  = bus.m_wreg;
  assign sbus.m_m2reg = bus.m_m2reg;
  assign sbus.m_rn    = bus.m_rn;
  assign sbus.m_alu   = bus.m_alu;
  assign sbus.m_mo    = bus.m_mo;
  assign sbus.id_rs   = bus.id_rs;
  assign sbus.id_rt   = bus.id_rt;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".w_valid"}, 32'(bus.w_valid), 32'd0);
    chk({tag, ".w_wreg"},  32'(bus.w_wreg),  32'd0);
    chk({tag, ".w_rn"},    32'(bus.w_rn),    32'd0);
    chk({tag, ".w_wdi"},   bus.w_wdi,        32'd0);
    chk({tag, ".fwd_a"},   32'(bus.fwd_a),   32'd0);
    chk({tag, ".fwd_b"},   32'(bus.fwd_b),   32'd0);
    chk({tag, ".retired"}, bus.retired,      32'd0);
    chk({tag, ".sretired"}, 32'(sbus.retired), 32'd0);
  endtask

  function automatic vec_t mk(
    input logic st, input logic fl, input logic mv, input logic mw, input logic mm,
    input logic [4:0] rn, input logic [31:0] alu, input logic [31:0] mo,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic ev, input logic ew, input logic [4:0] ern, input logic [31:0] ewdi,
    input logic efa, input logic efb, input logic [31:0] eret);
    vec_t v;
    v.stall = st; v.flush = fl; v.mv = mv; v.mw = mw; v.mm = mm;
    v.rn = rn; v.alu = alu; v.mo = mo; v.rs = rs; v.rt = rt;
    v.ev = ev; v.ew = ew; v.ern = ern; v.ewdi = ewdi;
    v.efa = efa; v.efb = efb; v.eret = eret;
    return v;
  endfunction

  // Drive a vector for the next rising edge and queue its expected result.
  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.stall   = v.stall;
    bus.flush   = v.flush;
    bus.m_valid = v.mv;
    bus.m_wreg  = v.mw;
    bus.m_m2reg = v.mm;
    bus.m_rn    = v.rn;
    bus.m_alu   = v.alu;
    bus.m_mo    = v.mo;
    bus.id_rs   = v.rs;
    bus.id_rt   = v.rt;
    expq.push_back(v);
  endtask

  // Monitor: compare WB outputs just after each rising edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("w_valid", 32'(bus.w_valid), 32'(e.ev));
        chk("w_wreg",  32'(bus.w_wreg),  32'(e.ew));
        chk("w_rn",    32'(bus.w_rn),    32'(e.ern));
        chk("w_wdi",   bus.w_wdi,        e.ewdi);
        chk("fwd_a",   32'(bus.fwd_a),   32'(e.efa));
        chk("fwd_b",   32'(bus.fwd_b),   32'(e.efb));
        chk("retired", bus.retired,      e.eret);
        chk("retired4", 32'(sbus.retired), {28'd0, e.eret[3:0]});
      end
    end
  end

  initial begin
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.m_valid = 1'b0; bus.m_wreg = 1'b0; bus.m_m2reg = 1'b0;
    bus.m_rn = '0; bus.m_alu = '0; bus.m_mo = '0;
    bus.id_rs = '0; bus.id_rt = '0;

    #3 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;

    //            st fl mv mw mm rn     alu           mo            rs     rt     ev ew ern    wdi           fa fb ret
    apply(mk(1'b0,1'b0,1'b1,1'b1,1'b1,5'd3, 32'h4,        32'h0000000A, 5'd3, 5'd0, 1'b1,1'b1,5'd3, 32'h0000000A, 1'b1,1'b0,32'd0));
    apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0,5'd7, 32'h12345678, 32'h0,        5'd7, 5'd2, 1'b1,1'b1,5'd7, 32'h12345678, 1'b1,1'b0,32'd1));
    apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0,5'd0, 32'hFFFFFFFF, 32'h0,        5'd0, 5'd0, 1'b1,1'b0,5'd0, 32'hFFFFFFFF, 1'b0,1'b0,32'd2));
    apply(mk(1'b0,1'b0,1'b0,1'b1,1'b0,5'd9, 32'h55,       32'h0,        5'd9, 5'd9, 1'b0,1'b0,5'd9, 32'h55,       1'b0,1'b0,32'd3));
    apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0,5'd5, 32'h500,      32'h0,        5'd5, 5'd0, 1'b1,1'b1,5'd5, 32'h500,      1'b1,1'b0,32'd3));
    for (int i = 0; i < 3; i++)
      apply(mk(1'b1,1'b0,1'b1,1'b1,1'b1,5'd6, 32'hDEAD,   32'hBEEF,     5'd5, 5'd5, 1'b1,1'b1,5'd5, 32'h500,      1'b1,1'b1,32'd3));
    apply(mk(1'b1,1'b1,1'b1,1'b1,1'b1,5'd6, 32'hDEAD,     32'hBEEF,     5'd5, 5'd5, 1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,32'd3));
    apply(mk(1'b0,1'b0,1'b1,1'b1,1'b1,5'd4, 32'h1,        32'hCAFE,     5'd0, 5'd4, 1'b1,1'b1,5'd4, 32'hCAFE,     1'b0,1'b1,32'd3));
    apply(mk(1'b0,1'b1,1'b1,1'b1,1'b0,5'd8, 32'h88,       32'h0,        5'd8, 5'd0, 1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,32'd4));
    apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,32'd4));
    apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0,5'd2, 32'h22,       32'h0,        5'd2, 5'd2, 1'b1,1'b1,5'd2, 32'h22,       1'b1,1'b1,32'd4));

    // Asynchronous reset between edges while a write is in WB.
    @(negedge clk);
    chk("pre_rst.w_wreg", 32'(bus.w_wreg), 32'd1);
    #1 clrn = 1'b0;
    #1 chk_zero("async_rst");
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1 chk_zero("rst_hold");
    @(negedge clk);
    clrn = 1'b1;

    // Back-to-back retirements; the 4-bit counter wraps 15 -> 0.
    for (int k = 0; k < 20; k++) begin
      logic [4:0] r;
      r = 5'((k % 31) + 1);
      apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0, r, 32'h100 + 32'(k), 32'h0, r, 5'd0,
               1'b1,1'b1, r, 32'h100 + 32'(k), 1'b1,1'b0, 32'(k)));
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
